clk_period_meter: RTL and testbench
===================================

CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 Parameter CNT_W, default 32: width of the cycle counter and of the period output.
REQ-002 Parameter TIMEOUT, default 100000000: clkin cycles without a rising edge before a timeout is declared.
REQ-003 Parameter TOL, default 64: +/- cycle tolerance used for selector classification.
REQ-004 Port list:
- clkin  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- sig_in  input  1  divided clock under measurement; asynchronous to clkin.
- period  output  CNT_W  clkin cycles between the last two sig_in rising edges.
- period_valid  output  1  one-cycle pulse when period updates.
- sel_code  output  8  selector value reconstructed from period.
- timeout  output  1  level; high while sig_in is stalled.
- locked  output  1  level; high once at least one full period has been measured since reset or timeout.

Function
REQ-005 sig_in SHALL pass through a 2-flop synchronizer; rising edges SHALL be detected on the synchronized signal.
- An edge is detected 3 clkin cycles after sig_in rises.
REQ-006 States:
- IDLE: counter cleared; first edge -> MEASURE.
- MEASURE: counter increments each cycle; each edge -> period update.
- STALL: entered on timeout.
REQ-007 In MEASURE, on an edge:
- period <= counter + 1; the count includes the edge cycle.
- Counter restarts at 0 on the same cycle.
- period_valid SHALL pulse on the following cycle.
REQ-008 Successive edges exactly N clkin cycles apart SHALL report period = N.
REQ-009 If counter reaches TIMEOUT-1 without an edge in MEASURE or IDLE:
- Go to STALL; timeout <= 1 and locked <= 0.
- period holds its last value.
REQ-010 In STALL, an edge SHALL clear timeout, go to MEASURE and restart the counter; no period_valid is produced for that edge.
REQ-011 Counter SHALL saturate at all-ones and never wrap.
REQ-012 If an edge and the timeout condition occur in the same cycle, the edge SHALL win.
REQ-013 sel_code SHALL be combinationally derived from period, registered with period_valid:
- 16 if |period - 50000002| <= TOL.
- 48 if |period - 100000002| <= TOL.
- 0 if |period - 5002| <= TOL.
- 8'hFF otherwise.
REQ-014 locked SHALL rise with the first period_valid after IDLE or STALL.

Reset
REQ-015 With rst_n = 0 at a clkin rising edge:
- period = 0, period_valid = 0, sel_code = 8'hFF, timeout = 0, locked = 0.
- Synchronizer flops = 0, counter = 0, state = IDLE.
REQ-016 Reset asserted mid-measurement SHALL discard the partial count.
- The first edge after release is treated as an IDLE edge and produces no period.

Configuration
REQ-017 Macro CLK_PERIOD_METER_AVG_EN.
- When defined: period SHALL be the mean of the last 4 measured periods (sum >> 2, sum width CNT_W+2). period_valid and locked SHALL assert only after 4 periods have accumulated; the history clears on reset or STALL.
- When undefined: single-period behaviour per REQ-007 and no history registers.

Structure
REQ-018 Package clk_meter_pkg SHALL hold:
- The state enum (IDLE, MEASURE, STALL).
- Nominal period constants 5002, 50000002 and 100000002.
- Selector codes 0, 16, 48 and 8'hFF.
REQ-019 Sub-module sync_edge_det SHALL contain the 2-flop synchronizer and the rising-edge pulse generator.

Verification (TIMEOUT = 20000 overridden for simulation)
REQ-020 sig_in toggling every 2501 cycles (period 5002) -> period = 5002, sel_code = 0, locked = 1 after the second edge.
REQ-021 Period 5002 + 60 -> sel_code = 0; period 5002 + 65 -> sel_code = 8'hFF.
REQ-022 sig_in held low for 20000 cycles after lock -> timeout = 1 and locked = 0 with period unchanged; the next edge -> timeout = 0 and no period_valid pulse.
REQ-023 Edge injected on the exact timeout cycle -> no timeout; period = 20000.
REQ-024 rst_n pulsed low mid-period -> all outputs at reset values; the first edge after release produces no period_valid.
REQ-025 With CLK_PERIOD_METER_AVG_EN, periods 5000, 5004, 5000, 5004 -> a single period_valid with period = 5002 on the fourth measurement.

Source files
------------

// File: rtl/clk_meter_pkg.sv
// Shared types, nominal periods and selector codes for the clock period meter.
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALL   = 2'd2
  } state_e;

  localparam int unsigned CMP_W    = 64;
  localparam int unsigned NOM_5K   = 5002;
  localparam int unsigned NOM_50M  = 50000002;
  localparam int unsigned NOM_100M = 100000002;

  localparam logic [7:0] SEL_5K   = 8'd0;
  localparam logic [7:0] SEL_50M  = 8'd16;
  localparam logic [7:0] SEL_100M = 8'd48;
  localparam logic [7:0] SEL_NONE = 8'hFF;

  function automatic logic [CMP_W-1:0] abs_diff(input logic [CMP_W-1:0] a,
                                                 input logic [CMP_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Map a measured period onto the divider selector that produces it.
  function automatic logic [7:0] classify(input logic [CMP_W-1:0] period,
                                          input logic [CMP_W-1:0] tol);
    logic [7:0] sel;
    sel = SEL_NONE;
    if (abs_diff(period, CMP_W'(NOM_50M)) <= tol)       sel = SEL_50M;
    else if (abs_diff(period, CMP_W'(NOM_100M)) <= tol) sel = SEL_100M;
    else if (abs_diff(period, CMP_W'(NOM_5K)) <= tol)   sel = SEL_5K;
    return sel;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input plus a rising-edge pulse
// on the synchronized copy.
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_c_o
);

  // [0],[1] are the synchronizer; [2] is the delayed copy for edge detection.
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  assign sync_d = {sync_q[1:0], sig_i};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= sync_d;
  end

  assign rise_c_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period of sig_in in clkin cycles and classifies it to a selector.
// Optional 4-period averaging is enabled by defining CLK_PERIOD_METER_AVG_EN.
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 100000000,
  parameter int unsigned TOL     = 64
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [7:0]       sel_code,
  output logic             timeout,
  output logic             locked
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_c;
  logic [CNT_W-1:0] period_q, period_d;
  logic             upd_q, upd_d;
  logic             pv_q, pv_d;
  logic [7:0]       sel_q, sel_d;
  logic             timeout_q, timeout_d;
  logic             locked_q, locked_d;
  logic             rise_c;
  logic             hit_to_c;

  sync_edge_det u_sync (
    .clk_i    (clkin),
    .rst_ni   (rst_n),
    .sig_i    (sig_in),
    .rise_c_o (rise_c)
  );

  assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign hit_to_c  = (cnt_q == TO_LAST);

`ifdef CLK_PERIOD_METER_AVG_EN
  localparam int unsigned SUM_W  = CNT_W + 2;
  localparam int unsigned HIST_N = 3;

  // The three previous periods; the current one completes the window of four.
  logic [CNT_W-1:0] hist_q [HIST_N];
  logic [CNT_W-1:0] hist_d [HIST_N];
  logic [2:0]       fill_q, fill_d;
  logic [SUM_W-1:0] sum_c;

  assign sum_c = SUM_W'(cnt_inc_c) + SUM_W'(hist_q[0]) + SUM_W'(hist_q[1]) + SUM_W'(hist_q[2]);

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      fill_q <= '0;
      for (int i = 0; i < int'(HIST_N); i++) hist_q[i] <= '0;
    end else begin
      fill_q <= fill_d;
      for (int i = 0; i < int'(HIST_N); i++) hist_q[i] <= hist_d[i];
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_inc_c;
    period_d  = period_q;
    upd_d     = 1'b0;
    pv_d      = upd_q;
    sel_d     = upd_q ? classify(CMP_W'(period_q), CMP_W'(TOL)) : sel_q;
    timeout_d = timeout_q;
    locked_d  = locked_q | upd_q;
`ifdef CLK_PERIOD_METER_AVG_EN
    hist_d = hist_q;
    fill_d = fill_q;
`endif
    case (state_q)
      IDLE, MEASURE: begin
        // An edge on the timeout cycle takes priority over the timeout.
        if (rise_c) begin
          state_d = MEASURE;
          cnt_d   = '0;
          if (state_q == MEASURE) begin
`ifdef CLK_PERIOD_METER_AVG_EN
            hist_d[2] = hist_q[1];
            hist_d[1] = hist_q[0];
            hist_d[0] = cnt_inc_c;
            fill_d    = (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
            if (fill_q >= 3'd3) begin
              period_d = sum_c[SUM_W-1:2];
              upd_d    = 1'b1;
            end
`else
            period_d = cnt_inc_c;
            upd_d    = 1'b1;
`endif
          end
        end else if (hit_to_c) begin
          state_d   = STALL;
          cnt_d     = '0;
          timeout_d = 1'b1;
          locked_d  = 1'b0;
`ifdef CLK_PERIOD_METER_AVG_EN
          fill_d = '0;
          for (int i = 0; i < int'(HIST_N); i++) hist_d[i] = '0;
`endif
        end
      end
      STALL: begin
        cnt_d = '0;
        if (rise_c) begin
          state_d   = MEASURE;
          timeout_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      upd_q     <= 1'b0;
      pv_q      <= 1'b0;
      sel_q     <= SEL_NONE;
      timeout_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      upd_q     <= upd_d;
      pv_q      <= pv_d;
      sel_q     <= sel_d;
      timeout_q <= timeout_d;
      locked_q  <= locked_d;
    end
  end

  assign period       = period_q;
  assign period_valid = pv_q;
  assign sel_code     = sel_q;
  assign timeout      = timeout_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed self-checking bench for clk_period_meter (TIMEOUT reduced to 20000).
// Defining CLK_PERIOD_METER_AVG_EN selects the averaging scenario.
module tb_clk_period_meter;

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned TIMEOUT = 20000;
  localparam int unsigned TOL     = 64;

  logic             clkin = 1'b0;
  logic             rst_n;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic [7:0]       sel_code;
  logic             timeout;
  logic             locked;

  int         cyc = 0;
  int         last_rise = 0;
  int         pv_count = 0;
  int         pv_base = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  logic [31:0] last_period = '0;
  logic [7:0]  last_sel = '0;
  bit          to_seen = 1'b0;

  clk_period_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .TOL     (TOL)
  ) dut (
    .clkin        (clkin),
    .rst_n        (rst_n),
    .sig_in       (sig_in),
    .period       (period),
    .period_valid (period_valid),
    .sel_code     (sel_code),
    .timeout      (timeout),
    .locked       (locked)
  );

  always #5 clkin = ~clkin;

  always @(posedge clkin) cyc++;

  always @(negedge clkin) begin
    if (period_valid) begin
      pv_count++;
      last_period = period;
      last_sel    = sel_code;
    end
    if (timeout) to_seen = 1'b1;
  end

  initial begin
    #(2000000);
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clkin);
    #2;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) step(1);
  endtask

  // Next sig_in rising edge exactly n clkin cycles after the previous one.
  task automatic rise_after(input int n);
    wait_to(last_rise + n / 2);
    sig_in = 1'b0;
    wait_to(last_rise + n);
    sig_in = 1'b1;
    last_rise = last_rise + n;
  endtask

  task automatic expect_result(input string tag, input int exp_cnt,
                               input logic [31:0] exp_p, input logic [7:0] exp_s);
    step(8);
    @(negedge clkin);
    check({tag, "_pv_count"}, 64'(pv_count), 64'(exp_cnt));
    check({tag, "_period"}, 64'(last_period), 64'(exp_p));
    check({tag, "_sel"}, 64'(last_sel), 64'(exp_s));
    check({tag, "_locked"}, 64'(locked), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_period"}, 64'(period), 64'd0);
    check({tag, "_period_valid"}, 64'(period_valid), 64'd0);
    check({tag, "_sel"}, 64'(sel_code), 64'hFF);
    check({tag, "_timeout"}, 64'(timeout), 64'd0);
    check({tag, "_locked"}, 64'(locked), 64'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    sig_in = 1'b0;
    step(3);
    @(negedge clkin);
    check_reset_outputs("reset");
    step(1);
    rst_n = 1'b1;
    step(5);
    sig_in = 1'b1;
    last_rise = cyc;
    step(20);
    @(negedge clkin);
    check("first_edge_no_lock", 64'(locked), 64'd0);
    check("first_edge_no_pv", 64'(pv_count), 64'd0);

`ifdef CLK_PERIOD_METER_AVG_EN
    rise_after(5000);
    rise_after(5004);
    rise_after(5000);
    step(8);
    @(negedge clkin);
    check("avg_partial_pv", 64'(pv_count), 64'd0);
    check("avg_partial_locked", 64'(locked), 64'd0);
    rise_after(5004);
    expect_result("avg4", 1, 32'd5002, 8'h00);
`else
    begin
      int         gaps [3] = '{5062, 5067, 4938};
      logic [7:0] sels [3] = '{8'h00, 8'hFF, 8'h00};
      rise_after(5002);
      expect_result("p5002", 1, 32'd5002, 8'h00);
      check("p5002_timeout", 64'(timeout), 64'd0);
      for (int i = 0; i < 3; i++) begin
        rise_after(gaps[i]);
        expect_result($sformatf("tol_%0d", gaps[i]), 2 + i, 32'(gaps[i]), sels[i]);
      end
    end

    // Stall: hold sig_in low past the timeout.
    pv_base = pv_count;
    step(1);
    sig_in = 1'b0;
    wait_to(last_rise + 19990);
    @(negedge clkin);
    check("pre_timeout", 64'(timeout), 64'd0);
    wait_to(last_rise + 20015);
    @(negedge clkin);
    check("stall_timeout", 64'(timeout), 64'd1);
    check("stall_locked", 64'(locked), 64'd0);
    check("stall_period_held", 64'(period), 64'd4938);
    check("stall_no_pv", 64'(pv_count), 64'(pv_base));

    step(1);
    sig_in = 1'b1;
    last_rise = cyc;
    step(8);
    @(negedge clkin);
    check("recover_timeout", 64'(timeout), 64'd0);
    check("recover_no_pv", 64'(pv_count), 64'(pv_base));
    check("recover_locked", 64'(locked), 64'd0);

    // Edge on the exact timeout cycle must win.
    to_seen = 1'b0;
    rise_after(20000);
    expect_result("edge_on_timeout", pv_base + 1, 32'd20000, 8'hFF);
    check("edge_on_timeout_no_to", 64'(to_seen), 64'd0);

    // Reset in the middle of a period.
    pv_base = pv_count;
    wait_to(last_rise + 600);
    sig_in = 1'b0;
    rst_n  = 1'b0;
    step(2);
    @(negedge clkin);
    check_reset_outputs("midreset");
    step(1);
    rst_n = 1'b1;
    step(5);
    sig_in = 1'b1;
    last_rise = cyc;
    step(10);
    @(negedge clkin);
    check("postreset_no_pv", 64'(pv_count), 64'(pv_base));
    check("postreset_locked", 64'(locked), 64'd0);
    rise_after(5002);
    expect_result("postreset_p5002", pv_base + 1, 32'd5002, 8'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
